gcn_mem_read_arbiter: RTL and testbench

- Shares the single feature/weight memory read port between two requesters:
  - requester 0: transformation block (feature/weight fetch).
  - requester 1: combination block (adjacency/COO fetch).
- Round-robin grant with burst locking and a maximum burst length for fairness.
- Tags returned data so each requester sees its own read-valid strobe.
- Sits between the requester read_address/enable_read outputs and the input memory.

---
 rtl/gcn_mem_read_arbiter.sv | 167 ++++++++++++++++
 tb/tb_gcn_mem_read_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_mem_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gcn_mem_read_arbiter
//  Purpose  : Round-robin arbiter sharing the feature/weight memory read port
//             between the transformation block (req0) and the combination
//             block (req1). Grants are burst-locked with a maximum burst
//             length, and returned data is tagged with a per-requester
//             read-valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module gcn_mem_read_arbiter #(
    parameter int ADDRESS_WIDTH   = 13,
    parameter int MAX_BURST       = 96,
    parameter int READ_LATENCY    = 1,
    parameter int BURST_CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_enable_read,
    input  logic [ADDRESS_WIDTH-1:0] req0_read_address,
    input  logic                     req1_enable_read,
    input  logic [ADDRESS_WIDTH-1:0] req1_read_address,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     mem_enable_read,
    output logic [ADDRESS_WIDTH-1:0] mem_read_address,
    output logic                     rvalid0,
    output logic                     rvalid1
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_grant0 = 2'd1;
    localparam logic [1:0] c_st_grant1 = 2'd2;

    localparam logic [BURST_CNT_WIDTH-1:0] c_max_burst = BURST_CNT_WIDTH'(MAX_BURST);
    localparam logic [BURST_CNT_WIDTH-1:0] c_cnt_one   = BURST_CNT_WIDTH'(1);

    logic [1:0]                 r_state;
    logic [1:0]                 w_next_state;
    logic                       r_last_served;
    logic                       w_next_last_served;
    logic [BURST_CNT_WIDTH-1:0] r_burst_cnt;
    logic [BURST_CNT_WIDTH-1:0] w_next_burst_cnt;
    logic [BURST_CNT_WIDTH-1:0] w_cnt_inc;
    logic                       w_issue0;
    logic                       w_issue1;

    // Read-valid tag pipeline: stage READ_LATENCY-1 lines up with memory data.
    logic [READ_LATENCY-1:0]    r_pipe_valid;
    logic [READ_LATENCY-1:0]    r_pipe_id;

    // A requester issues only in its own grant state while it holds its request.
    assign w_issue0 = (r_state == c_st_grant0) && req0_enable_read;
    assign w_issue1 = (r_state == c_st_grant1) && req1_enable_read;
    assign w_cnt_inc = r_burst_cnt + c_cnt_one;

    assign gnt0            = (r_state == c_st_grant0);
    assign gnt1            = (r_state == c_st_grant1);
    assign mem_enable_read = w_issue0 || w_issue1;

    // Address mux onto the shared port; zero when nothing is issued.
    always_comb begin
        mem_read_address = '0;
        if (w_issue0) begin
            mem_read_address = req0_read_address;
        end else if (w_issue1) begin
            mem_read_address = req1_read_address;
        end
    end

    // Arbitration state, last-served and burst-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_last_served <= 1'b1;
            r_burst_cnt   <= '0;
        end else begin
            r_state       <= w_next_state;
            r_last_served <= w_next_last_served;
            r_burst_cnt   <= w_next_burst_cnt;
        end
    end

    // Next-state logic: round-robin from IDLE, burst lock with forced switch at MAX_BURST.
    always_comb begin
        w_next_state       = r_state;
        w_next_last_served = r_last_served;
        w_next_burst_cnt   = r_burst_cnt;
        case (r_state)
            c_st_idle: begin
                w_next_burst_cnt = '0;
                // With both pending, the one not served last wins.
                if (req0_enable_read && (!req1_enable_read || r_last_served)) begin
                    w_next_state = c_st_grant0;
                end else if (req1_enable_read) begin
                    w_next_state = c_st_grant1;
                end
            end
            c_st_grant0: begin
                if (!req0_enable_read) begin
                    // Release takes priority over a coincident burst limit.
                    w_next_state       = req1_enable_read ? c_st_grant1 : c_st_idle;
                    w_next_last_served = 1'b0;
                    w_next_burst_cnt   = '0;
                end else if (w_cnt_inc == c_max_burst) begin
                    w_next_burst_cnt = '0;
                    if (req1_enable_read) begin
                        w_next_state       = c_st_grant1;
                        w_next_last_served = 1'b0;
                    end
                end else begin
                    w_next_burst_cnt = w_cnt_inc;
                end
            end
            c_st_grant1: begin
                if (!req1_enable_read) begin
                    w_next_state       = req0_enable_read ? c_st_grant0 : c_st_idle;
                    w_next_last_served = 1'b1;
                    w_next_burst_cnt   = '0;
                end else if (w_cnt_inc == c_max_burst) begin
                    w_next_burst_cnt = '0;
                    if (req0_enable_read) begin
                        w_next_state       = c_st_grant0;
                        w_next_last_served = 1'b1;
                    end
                end else begin
                    w_next_burst_cnt = w_cnt_inc;
                end
            end
            default: begin
                w_next_state     = c_st_idle;
                w_next_burst_cnt = '0;
            end
        endcase
    end

    // First pipeline stage captures the issue strobe and the issuing requester id.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_valid[0] <= 1'b0;
            r_pipe_id[0]    <= 1'b0;
        end else begin
            r_pipe_valid[0] <= mem_enable_read;
            r_pipe_id[0]    <= w_issue1;
        end
    end

    generate
        for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe_stage
            // Remaining stages delay the tag in order, so ordering survives a switch.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pipe_valid[gi] <= 1'b0;
                    r_pipe_id[gi]    <= 1'b0;
                end else begin
                    r_pipe_valid[gi] <= r_pipe_valid[gi-1];
                    r_pipe_id[gi]    <= r_pipe_id[gi-1];
                end
            end
        end
    endgenerate

    assign rvalid0 = r_pipe_valid[READ_LATENCY-1] && !r_pipe_id[READ_LATENCY-1];
    assign rvalid1 = r_pipe_valid[READ_LATENCY-1] &&  r_pipe_id[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_gcn_mem_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcn_mem_read_arbiter
//  Purpose  : Directed self-checking bench for gcn_mem_read_arbiter. Two
//             instances share stimulus: MAX_BURST=4 with READ_LATENCY=1 and
//             READ_LATENCY=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gcn_mem_read_arbiter;

    localparam int AW = 13;

    logic          clk;
    logic          reset;
    logic          req0_enable_read;
    logic [AW-1:0] req0_read_address;
    logic          req1_enable_read;
    logic [AW-1:0] req1_read_address;

    logic          gnt0, gnt1, mem_enable_read, rvalid0, rvalid1;
    logic [AW-1:0] mem_read_address;
    logic          gnt0_l3, gnt1_l3, mem_enable_read_l3, rvalid0_l3, rvalid1_l3;
    logic [AW-1:0] mem_read_address_l3;

    int n_chk;
    int n_err;

    gcn_mem_read_arbiter #(
        .ADDRESS_WIDTH(AW), .MAX_BURST(4), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_enable_read(req0_enable_read), .req0_read_address(req0_read_address),
        .req1_enable_read(req1_enable_read), .req1_read_address(req1_read_address),
        .gnt0(gnt0), .gnt1(gnt1),
        .mem_enable_read(mem_enable_read), .mem_read_address(mem_read_address),
        .rvalid0(rvalid0), .rvalid1(rvalid1)
    );

    gcn_mem_read_arbiter #(
        .ADDRESS_WIDTH(AW), .MAX_BURST(4), .READ_LATENCY(3)
    ) dut_l3 (
        .clk(clk), .reset(reset),
        .req0_enable_read(req0_enable_read), .req0_read_address(req0_read_address),
        .req1_enable_read(req1_enable_read), .req1_read_address(req1_read_address),
        .gnt0(gnt0_l3), .gnt1(gnt1_l3),
        .mem_enable_read(mem_enable_read_l3), .mem_read_address(mem_read_address_l3),
        .rvalid0(rvalid0_l3), .rvalid1(rvalid1_l3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait for the falling edge and compare every output of the latency-1 instance.
    task automatic sample(input string tag, input logic g0, input logic g1, input logic en,
                          input int addr, input logic rv0, input logic rv1);
        @(negedge clk);
        chk({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
        chk({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
        chk({tag, ".en"},   32'(mem_enable_read), 32'(en));
        chk({tag, ".addr"}, 32'(mem_read_address), 32'(addr));
        chk({tag, ".rv0"},  32'(rvalid0), 32'(rv0));
        chk({tag, ".rv1"},  32'(rvalid1), 32'(rv1));
    endtask

    task automatic step(input string tag, input logic g0, input logic g1, input logic en,
                        input int addr, input logic rv0, input logic rv1);
        sample(tag, g0, g1, en, addr, rv0, rv1);
        cyc();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        req0_enable_read = 1'b0;
        req1_enable_read = 1'b0;
        req0_read_address = '0;
        req1_read_address = '0;
        cyc();
        cyc();

        // Reset state
        sample("rst", 0, 0, 0, 0, 0, 0);
        chk("rst.l3_rv0", 32'(rvalid0_l3), 32'd0);
        chk("rst.l3_rv1", 32'(rvalid1_l3), 32'd0);
        cyc();

        // Test 1: req0 alone for 6 cycles, burst counter wraps without switching
        reset = 1'b0;
        req0_enable_read = 1'b1;
        req0_read_address = 13'd0;
        step("t1_arb", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            req0_read_address = 13'(k);
            step("t1_issue", 1, 0, 1, k, k > 0, 0);
        end
        req0_enable_read = 1'b0;
        step("t1_drop", 1, 0, 0, 0, 1, 0);
        step("t1_idle", 0, 0, 0, 0, 0, 0);

        // Test 2: both requesters after reset, req0 first, forced switches at 4
        reset = 1'b1;
        step("t2_rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        req0_enable_read = 1'b1;
        req1_enable_read = 1'b1;
        req0_read_address = 13'd10;
        req1_read_address = 13'd100;
        step("t2_arb", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            req0_read_address = 13'(10 + k);
            step("t2_g0", 1, 0, 1, 10 + k, k > 0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            req1_read_address = 13'(100 + k);
            step("t2_g1", 0, 1, 1, 100 + k, k == 0, k > 0);
        end
        req0_read_address = 13'd14;
        step("t2_back0", 1, 0, 1, 14, 0, 1);
        req0_enable_read = 1'b0;
        req1_enable_read = 1'b0;
        step("t2_drop", 1, 0, 0, 0, 1, 0);
        step("t2_idle", 0, 0, 0, 0, 0, 0);

        // Test 3: req1 alone drops after 2 issues, then req0 arbitrates from IDLE
        req1_enable_read = 1'b1;
        req1_read_address = 13'd200;
        step("t3_arb", 0, 0, 0, 0, 0, 0);
        step("t3_g1a", 0, 1, 1, 200, 0, 0);
        req1_read_address = 13'd201;
        step("t3_g1b", 0, 1, 1, 201, 0, 1);
        req1_enable_read = 1'b0;
        step("t3_drop", 0, 1, 0, 0, 0, 1);
        step("t3_idle", 0, 0, 0, 0, 0, 0);
        req0_enable_read = 1'b1;
        req0_read_address = 13'd300;
        step("t3_arb0", 0, 0, 0, 0, 0, 0);
        step("t3_g0", 1, 0, 1, 300, 0, 0);
        req0_enable_read = 1'b0;
        step("t3_drop0", 1, 0, 0, 0, 1, 0);

        // Test 4: req1 drops on the cycle its 4th issue was due, req0 pending
        req0_enable_read = 1'b1;
        req1_enable_read = 1'b1;
        req0_read_address = 13'd500;
        req1_read_address = 13'd400;
        step("t4_arb", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            req1_read_address = 13'(400 + k);
            step("t4_g1", 0, 1, 1, 400 + k, 0, k > 0);
        end
        req1_enable_read = 1'b0;
        step("t4_drop", 0, 1, 0, 0, 0, 1);
        step("t4_sw0", 1, 0, 1, 500, 0, 0);
        step("t4_hold0", 1, 0, 1, 500, 1, 0);
        req0_enable_read = 1'b0;
        step("t4_drop0", 1, 0, 0, 0, 1, 0);
        step("t4_idle", 0, 0, 0, 0, 0, 0);

        // Test 5: READ_LATENCY=3 tag order across a 0->1->0 switch
        reset = 1'b1;
        step("t5_rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        req0_enable_read = 1'b1;
        req1_enable_read = 1'b1;
        req0_read_address = 13'd20;
        req1_read_address = 13'd40;
        step("t5_arb", 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 12; n++) begin
            req0_enable_read = (n < 8);
            req1_enable_read = (n < 8);
            @(negedge clk);
            chk("t5.gnt0", 32'(gnt0_l3), 32'(n < 4 || n == 8));
            chk("t5.gnt1", 32'(gnt1_l3), 32'(n >= 4 && n < 8));
            chk("t5.l3_rv0", 32'(rvalid0_l3), 32'(n >= 3 && n <= 6));
            chk("t5.l3_rv1", 32'(rvalid1_l3), 32'(n >= 7 && n <= 10));
            cyc();
        end

        // Test 6: reset mid-burst in GRANT0 with reads in flight
        req0_enable_read = 1'b1;
        req0_read_address = 13'd600;
        step("t6_arb", 0, 0, 0, 0, 0, 0);
        step("t6_g0a", 1, 0, 1, 600, 0, 0);
        req0_read_address = 13'd601;
        step("t6_g0b", 1, 0, 1, 601, 1, 0);
        reset = 1'b1;
        req1_enable_read = 1'b1;
        req1_read_address = 13'd700;
        req0_read_address = 13'd602;
        step("t6_rstcyc", 1, 0, 1, 602, 1, 0);
        reset = 1'b0;
        req0_enable_read = 1'b0;
        sample("t6_post", 0, 0, 0, 0, 0, 0);
        chk("t6_post.l3_rv0", 32'(rvalid0_l3), 32'd0);
        chk("t6_post.l3_rv1", 32'(rvalid1_l3), 32'd0);
        cyc();
        sample("t6_g1", 0, 1, 1, 700, 0, 0);
        chk("t6_g1.l3_rv0", 32'(rvalid0_l3), 32'd0);
        cyc();
        req1_enable_read = 1'b0;
        step("t6_drop1", 0, 1, 0, 0, 0, 1);
        step("t6_idle", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
